rtf_weight_apply: RTL and testbench

- Downstream consumer of the RTF pseudo-inverse stage.
- Reads the per-frequency 2x8 complex weight matrix that stage writes to result BRAM, and accepts one 8-mic STFT snapshot per frequency on a valid/ready stream.
- For each source s and frequency f, emits y[s] = sum over m of W[f][s][m]·x[m], then scales and narrows the result.
- Sweeps freq 0..FREQ_NUM-1 once per frame.

---
 rtl/rtf_weight_apply.sv | 203 ++++++++++++++++++++
 tb/tb_rtf_weight_apply.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtf_weight_apply.sv
// Applies the per-frequency SOR_NUMxMIC_NUM complex weight matrix to one mic snapshot per bin.
// Define BF_SAT_EN to saturate the narrowed output instead of wrapping it.
module rtf_weight_apply #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned W_WIDTH       = 48,
  parameter int unsigned MIC_NUM       = 8,
  parameter int unsigned SOR_NUM       = 2,
  parameter int unsigned FREQ_NUM      = 257,
  parameter int unsigned W_ADDR_WIDTH  = 32,
  parameter int unsigned W_ADDR_BASE   = 0,
  parameter int unsigned W_RD_INCREASE = 8,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned OUT_SHIFT     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic signed [DATA_WIDTH-1:0]   x_real,
  input  logic signed [DATA_WIDTH-1:0]   x_imag,
  output logic                           w_bram_rd_en,
  output logic        [W_ADDR_WIDTH-1:0] w_bram_rd_addr,
  input  logic signed [W_WIDTH-1:0]      w_bram_rd_real,
  input  logic signed [W_WIDTH-1:0]      w_bram_rd_imag,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic signed [OUT_WIDTH-1:0]    y_real,
  output logic signed [OUT_WIDTH-1:0]    y_imag,
  output logic                           y_src,
  output logic        [8:0]              y_freq,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int unsigned PROD_WIDTH = W_WIDTH + DATA_WIDTH + 1;
  localparam int unsigned ACC_WIDTH  = PROD_WIDTH + $clog2(MIC_NUM);
  localparam int unsigned RD_NUM     = SOR_NUM * MIC_NUM;
  localparam int unsigned MCNT_W     = $clog2(MIC_NUM);
  localparam int unsigned RCNT_W     = $clog2(RD_NUM + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, OUTPUT} state_t;

  state_t                         state;
  logic        [MCNT_W-1:0]       mcnt;
  logic        [RCNT_W-1:0]       rcnt;
  logic        [MCNT_W-1:0]       acc_m;
  logic                           acc_s;
  logic        [8:0]              freq;
  logic        [W_ADDR_WIDTH-1:0] next_addr;
  logic signed [DATA_WIDTH-1:0]   samp_re [MIC_NUM];
  logic signed [DATA_WIDTH-1:0]   samp_im [MIC_NUM];
  logic signed [ACC_WIDTH-1:0]    acc_re  [SOR_NUM];
  logic signed [ACC_WIDTH-1:0]    acc_im  [SOR_NUM];

  logic signed [PROD_WIDTH-1:0] wr_e, wi_e, xr_e, xi_e, prod_re, prod_im;

  // Full-precision complex product of the returning weight and its buffered sample
  always_comb begin
    wr_e    = PROD_WIDTH'(w_bram_rd_real);
    wi_e    = PROD_WIDTH'(w_bram_rd_imag);
    xr_e    = PROD_WIDTH'(samp_re[acc_m]);
    xi_e    = PROD_WIDTH'(samp_im[acc_m]);
    prod_re = wr_e * xr_e - wi_e * xi_e;
    prod_im = wr_e * xi_e + wi_e * xr_e;
  end

  function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
`ifdef BF_SAT_EN
    logic signed [ACC_WIDTH-1:0]   sh;
    logic [ACC_WIDTH-OUT_WIDTH:0]  hi;
    sh = a >>> OUT_SHIFT;
    hi = sh[ACC_WIDTH-1:OUT_WIDTH-1];
    // In range when every bit above the output sign bit matches it
    if ((&hi) || !(|hi)) narrow = sh[OUT_WIDTH-1:0];
    else                 narrow = {sh[ACC_WIDTH-1], {(OUT_WIDTH-1){~sh[ACC_WIDTH-1]}}};
`else
    narrow = OUT_WIDTH'(a >>> OUT_SHIFT);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mcnt           <= '0;
      rcnt           <= '0;
      acc_m          <= '0;
      acc_s          <= 1'b0;
      freq           <= '0;
      next_addr      <= W_ADDR_WIDTH'(W_ADDR_BASE);
      x_ready        <= 1'b0;
      w_bram_rd_en   <= 1'b0;
      w_bram_rd_addr <= '0;
      y_valid        <= 1'b0;
      y_real         <= '0;
      y_imag         <= '0;
      y_src          <= 1'b0;
      y_freq         <= '0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      for (int i = 0; i < MIC_NUM; i++) begin
        samp_re[i] <= '0;
        samp_im[i] <= '0;
      end
      for (int i = 0; i < SOR_NUM; i++) begin
        acc_re[i] <= '0;
        acc_im[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= COLLECT;
            x_ready <= 1'b1;
            busy    <= 1'b1;
            mcnt    <= '0;
          end
        end

        COLLECT: begin
          if (x_valid && x_ready) begin
            samp_re[mcnt] <= x_real;
            samp_im[mcnt] <= x_imag;
            if (mcnt == MCNT_W'(MIC_NUM - 1)) begin
              // Last mic in: start the weight read burst immediately
              mcnt           <= '0;
              x_ready        <= 1'b0;
              state          <= COMPUTE;
              rcnt           <= '0;
              acc_m          <= '0;
              acc_s          <= 1'b0;
              w_bram_rd_en   <= 1'b1;
              w_bram_rd_addr <= next_addr;
              next_addr      <= next_addr + W_ADDR_WIDTH'(W_RD_INCREASE);
              for (int i = 0; i < SOR_NUM; i++) begin
                acc_re[i] <= '0;
                acc_im[i] <= '0;
              end
            end else begin
              mcnt <= mcnt + MCNT_W'(1);
            end
          end
        end

        COMPUTE: begin
          rcnt <= rcnt + RCNT_W'(1);
          if (rcnt < RCNT_W'(RD_NUM - 1)) begin
            w_bram_rd_addr <= next_addr;
            next_addr      <= next_addr + W_ADDR_WIDTH'(W_RD_INCREASE);
          end else begin
            w_bram_rd_en <= 1'b0;
          end
          // Read data lags its request by one cycle
          if (rcnt != '0) begin
            acc_re[acc_s] <= acc_re[acc_s] + ACC_WIDTH'(prod_re);
            acc_im[acc_s] <= acc_im[acc_s] + ACC_WIDTH'(prod_im);
            if (acc_m == MCNT_W'(MIC_NUM - 1)) begin
              acc_m <= '0;
              acc_s <= acc_s + 1'b1;
            end else begin
              acc_m <= acc_m + MCNT_W'(1);
            end
          end
          if (rcnt == RCNT_W'(RD_NUM)) begin
            state   <= OUTPUT;
            y_valid <= 1'b1;
            y_src   <= 1'b0;
            y_freq  <= freq;
            y_real  <= narrow(acc_re[0]);
            y_imag  <= narrow(acc_im[0]);
          end
        end

        OUTPUT: begin
          if (y_ready) begin
            if (y_src == 1'(SOR_NUM - 1)) begin
              y_valid <= 1'b0;
              if (freq == 9'(FREQ_NUM - 1)) begin
                frame_done <= 1'b1;
                freq       <= '0;
                next_addr  <= W_ADDR_WIDTH'(W_ADDR_BASE);
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                freq    <= freq + 9'(1);
                state   <= COLLECT;
                x_ready <= 1'b1;
              end
            end else begin
              y_src  <= y_src + 1'b1;
              y_real <= narrow(acc_re[y_src + 1'b1]);
              y_imag <= narrow(acc_im[y_src + 1'b1]);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtf_weight_apply.sv
// Randomized bench for rtf_weight_apply: weight BRAM model, stream drivers and a
// per-bin matrix-vector reference scoreboard.
module tb_rtf_weight_apply;

  localparam int NF = 257;
  localparam int NW = NF * 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic signed [15:0] x_real = '0;
  logic signed [15:0] x_imag = '0;
  logic               w_bram_rd_en;
  logic [31:0]        w_bram_rd_addr;
  logic signed [47:0] w_bram_rd_real = '0;
  logic signed [47:0] w_bram_rd_imag = '0;
  logic               y_valid;
  logic               y_ready = 1'b0;
  logic signed [31:0] y_real, y_imag;
  logic               y_src;
  logic [8:0]         y_freq;
  logic               frame_done, busy;

  always #5 clk = ~clk;

  rtf_weight_apply dut (
    .clk(clk), .rst(rst), .en(en),
    .x_valid(x_valid), .x_ready(x_ready), .x_real(x_real), .x_imag(x_imag),
    .w_bram_rd_en(w_bram_rd_en), .w_bram_rd_addr(w_bram_rd_addr),
    .w_bram_rd_real(w_bram_rd_real), .w_bram_rd_imag(w_bram_rd_imag),
    .y_valid(y_valid), .y_ready(y_ready), .y_real(y_real), .y_imag(y_imag),
    .y_src(y_src), .y_freq(y_freq), .frame_done(frame_done), .busy(busy)
  );

  logic signed [47:0] wr_mem [NW];
  logic signed [47:0] wi_mem [NW];
  logic signed [15:0] cur_xr [8];
  logic signed [15:0] cur_xi [8];

  // One-cycle-latency weight BRAM
  always @(posedge clk) begin
    if (w_bram_rd_en) begin
      w_bram_rd_real <= wr_mem[w_bram_rd_addr / 8];
      w_bram_rd_imag <= wi_mem[w_bram_rd_addr / 8];
    end
  end

  typedef struct {
    logic               src;
    logic [8:0]         freq;
    logic signed [31:0] re;
    logic signed [31:0] im;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stall_req = 0;
  int stall_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input int f);
    if (f < 2) return 0;
    if (f < 4) return 1;
    if (f < 6) return 2;
    return 3;
  endfunction

  function automatic logic signed [31:0] narrow_ref(input logic signed [127:0] acc);
    logic signed [127:0] sh;
    sh = acc >>> 16;
`ifdef BF_SAT_EN
    if (sh > 128'sd2147483647) return 32'sh7fffffff;
    if (sh < -128'sd2147483648) return 32'sh80000000;
`endif
    return sh[31:0];
  endfunction

  task automatic setup_weights();
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < 2; s++)
        for (int m = 0; m < 8; m++) begin
          int idx = f * 16 + s * 8 + m;
          case (kind_of(f))
            0: begin wr_mem[idx] = (s == 0 && m == 0) ? 48'sd65536 : 48'sd0; wi_mem[idx] = 48'sd0; end
            1: begin wr_mem[idx] = 48'sd65536; wi_mem[idx] = 48'sd0; end
            2: begin wr_mem[idx] = 48'sh7fff_ffff_ffff; wi_mem[idx] = 48'sd0; end
            default: begin
              wr_mem[idx] = 48'({$urandom(), $urandom()});
              wi_mem[idx] = 48'({$urandom(), $urandom()});
            end
          endcase
        end
  endtask

  // y[s] = sum_m W[f][s][m] * x[m], computed at full width then narrowed
  task automatic model_freq(input int f);
    for (int s = 0; s < 2; s++) begin
      logic signed [127:0] ar, ai, a, b, c, d;
      ar = '0;
      ai = '0;
      for (int m = 0; m < 8; m++) begin
        a = 128'(wr_mem[f * 16 + s * 8 + m]);
        b = 128'(wi_mem[f * 16 + s * 8 + m]);
        c = 128'(cur_xr[m]);
        d = 128'(cur_xi[m]);
        ar = ar + a * c - b * d;
        ai = ai + a * d + b * c;
      end
      exp_q.push_back('{src: 1'(s), freq: 9'(f), re: narrow_ref(ar), im: narrow_ref(ai)});
    end
  endtask

  task automatic send_freq(input int f, input bit push);
    for (int m = 0; m < 8; m++)
      case (kind_of(f))
        0: begin cur_xr[m] = (m == 0) ? 16'sd100 : 16'sd0; cur_xi[m] = (m == 0) ? 16'sd50 : 16'sd0; end
        1: begin cur_xr[m] = 16'(m + 1); cur_xi[m] = 16'sd0; end
        2: begin cur_xr[m] = 16'sd32767; cur_xi[m] = 16'sd0; end
        default: begin cur_xr[m] = 16'($urandom()); cur_xi[m] = 16'($urandom()); end
      endcase
    if (push) model_freq(f);
    for (int m = 0; m < 8; m++) begin
      int n = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      x_real  = cur_xr[m];
      x_imag  = cur_xi[m];
      x_valid = 1'b1;
      do begin @(posedge clk); n++; end while (!x_ready && n < 2000);
      #1;
      x_valid = 1'b0;
      if (n >= 2000) begin
        check("x_accept_timeout", 64'(n), 64'(0));
        return;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_ready"}, 64'(x_ready), 64'(0));
    check({tag, "_rd_en"}, 64'(w_bram_rd_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(w_bram_rd_addr), 64'(0));
    check({tag, "_y_valid"}, 64'(y_valid), 64'(0));
    check({tag, "_y_real"}, 64'(y_real), 64'(0));
    check({tag, "_y_imag"}, 64'(y_imag), 64'(0));
    check({tag, "_y_src"}, 64'(y_src), 64'(0));
    check({tag, "_y_freq"}, 64'(y_freq), 64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Output acceptor: random readiness plus requested 5-cycle stalls at output start
  initial begin
    int left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (left == 0 && stall_req > stall_done && y_valid) begin
        left = 5;
        stall_done++;
      end
      if (left > 0) begin
        y_ready = 1'b0;
        left--;
      end else begin
        y_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: read addresses, hold stability, scoreboard, frame accounting
  initial begin
    int rd_cnt = 0;
    int frame_outs = 0;
    logic [31:0] last_addr = '0;
    bit hold_prev = 0;
    logic signed [31:0] sv_re = '0, sv_im = '0;
    logic sv_src = 1'b0;
    logic [8:0] sv_freq = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        rd_cnt = 0;
        frame_outs = 0;
        hold_prev = 0;
      end else begin
        if (w_bram_rd_en) begin
          check("rd_addr", 64'(w_bram_rd_addr), 64'(rd_cnt * 8));
          last_addr = w_bram_rd_addr;
          rd_cnt++;
        end
        if (hold_prev) begin
          check("hold_valid", 64'(y_valid), 64'(1));
          check("hold_re", 64'(y_real), 64'(sv_re));
          check("hold_im", 64'(y_imag), 64'(sv_im));
          check("hold_src", 64'(y_src), 64'(sv_src));
          check("hold_freq", 64'(y_freq), 64'(sv_freq));
        end
        hold_prev = y_valid && !y_ready;
        sv_re = y_real; sv_im = y_imag; sv_src = y_src; sv_freq = y_freq;
        if (y_valid) check("x_ready_in_output", 64'(x_ready), 64'(0));
        if (y_valid && y_ready) begin
          frame_outs++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("y_src", 64'(y_src), 64'(e.src));
            check("y_freq", 64'(y_freq), 64'(e.freq));
            check("y_real", 64'(y_real), 64'(e.re));
            check("y_imag", 64'(y_imag), 64'(e.im));
            if (e.freq < 2) begin
              check("unit_re", 64'(y_real), (e.src == 1'b0) ? 64'(100) : 64'(0));
              check("unit_im", 64'(y_imag), (e.src == 1'b0) ? 64'(50) : 64'(0));
            end else if (e.freq < 4) begin
              check("sum_re", 64'(y_real), 64'(36));
              check("sum_im", 64'(y_imag), 64'(0));
            end
`ifdef BF_SAT_EN
            else if (e.freq < 6) check("sat_re", 64'(y_real), 64'(32'sh7fffffff));
`endif
          end
        end
        if (frame_done) begin
          done_cnt++;
          check("frame_outputs", 64'(frame_outs), 64'(514));
          check("last_rd_addr", 64'(last_addr), 64'(32888));
          check("rd_count", 64'(rd_cnt), 64'(NW));
          frame_outs = 0;
          rd_cnt = 0;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    setup_weights();
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: all bins, with a forced output stall on bin 6
    for (int f = 0; f < NF; f++) begin
      send_freq(f, 1'b1);
      if (f == 6) stall_req++;
    end
    n = 0;
    while (done_cnt < 1 && n < 5000) begin @(posedge clk); n++; end
    #1;
    check("frame_done_count", 64'(done_cnt), 64'(1));
    check("frame_idle_or_restart", 64'(exp_q.size()), 64'(0));

    // Frame 2: a few bins, then async reset in the middle of COMPUTE
    for (int f = 0; f < 3; f++) send_freq(f, 1'b1);
    send_freq(3, 1'b0);
    n = 0;
    while (!w_bram_rd_en && n < 2000) begin @(posedge clk); n++; end
    check("wait_compute", 64'(n < 2000), 64'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(busy), 64'(0));
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 4; f++) send_freq(f, 1'b1);
    n = 0;
    while ((exp_q.size() != 0 || y_valid) && n < 2000) begin @(posedge clk); n++; end
    #1;
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("frame_done_total", 64'(done_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
